// File: rtl/zuc256_pkg.sv
// Shared types and helpers for the ZUC-256 receive-side tag checker.
package zuc256_pkg;

    // Command currently being handed to the MAC engine
    typedef enum logic [1:0] {
        CMD_INIT  = 2'd0,
        CMD_NEXT  = 2'd1,
        CMD_FINAL = 2'd2
    } cmd_e;

    // Verification sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_READY = 3'd3,
        ST_CMP   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [7:0] TAG_LEN_32  = 8'd32;
    localparam logic [7:0] TAG_LEN_64  = 8'd64;
    localparam logic [7:0] TAG_LEN_128 = 8'd128;

    // Right-aligned mask selecting the tag bits that take part in the compare
    function automatic logic [127:0] tag_mask(input logic [7:0] len);
        logic [127:0] m;
        case (len)
            TAG_LEN_32: m = {96'h0, 32'hFFFF_FFFF};
            TAG_LEN_64: m = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
            default:    m = {128{1'b1}};
        endcase
        return m;
    endfunction

    // Only the three supported tag lengths are accepted
    function automatic logic tag_len_ok(input logic [7:0] len);
        logic ok;
        case (len)
            TAG_LEN_32, TAG_LEN_64, TAG_LEN_128: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/zuc256_tag_cmp.sv
// Masked tag comparator: XOR the two tags, mask, and OR-reduce across the
// full width so the evaluation time never depends on where bits differ.
module zuc256_tag_cmp
    import zuc256_pkg::*;
(
    input  logic [127:0] gen_tag,
    input  logic [127:0] ref_tag,
    input  logic [127:0] mask,
    output logic         match
);

    logic [127:0] diff_s;

    assign diff_s = (gen_tag ^ ref_tag) & mask;
    assign match  = ~(|diff_s);

endmodule

// File: rtl/zuc256_mac_verify.sv
// Receiver-side ZUC-256 tag checker. Drives zuc256_mac_ext through
// init/next/final, then compares the generated tag against the received one
// over the low tag_len bits and holds a sticky pass/fail result.
module zuc256_mac_verify
    import zuc256_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    input  logic         final_i,
    input  logic [127:0] block_i,
    input  logic [7:0]   i_len,
    input  logic [7:0]   tag_len,
    input  logic [127:0] tag_i,
    output logic         mac_init,
    output logic         mac_next,
    output logic         mac_final,
    output logic [127:0] mac_block,
    output logic [7:0]   mac_i_len,
    output logic [7:0]   mac_tag_len,
    input  logic [127:0] mac_tag,
    input  logic         mac_ready,
    output logic         ready,
    output logic         done,
    output logic         tag_ok,
    output logic         error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] TIMER_ONE  = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);

    state_e       state_r, state_s;
    cmd_e         cmd_r, cmd_s;
    logic [7:0]   tag_len_r, tag_len_s;
    logic [127:0] tag_ref_r, tag_ref_s;
    logic [127:0] block_r, block_s;
    logic [7:0]   i_len_r, i_len_s;
    logic [TW-1:0] timer_r, timer_s;
    logic         done_r, done_s;
    logic         tag_ok_r, tag_ok_s;
    logic         error_r, error_s;
    logic         mac_init_r, mac_next_r, mac_final_r;
    logic         ready_r;
    logic         match_s;

    zuc256_tag_cmp u_tag_cmp (
        .gen_tag (mac_tag),
        .ref_tag (tag_ref_r),
        .mask    (tag_mask(tag_len_r)),
        .match   (match_s)
    );

    // Next-state and register-update decode for the verification sequencer
    always_comb begin
        state_s   = state_r;
        cmd_s     = cmd_r;
        tag_len_s = tag_len_r;
        tag_ref_s = tag_ref_r;
        block_s   = block_r;
        i_len_s   = i_len_r;
        timer_s   = timer_r;
        done_s    = done_r;
        tag_ok_s  = tag_ok_r;
        error_s   = error_r;
        case (state_r)
            ST_IDLE, ST_READY, ST_DONE: begin
                if (init) begin
                    tag_len_s = tag_len;
                    done_s    = 1'b0;
                    tag_ok_s  = 1'b0;
                    if (tag_len_ok(tag_len)) begin
                        tag_ref_s = tag_i;
                        error_s   = 1'b0;
                        cmd_s     = CMD_INIT;
                        state_s   = ST_ISSUE;
                    end else begin
                        // Unsupported length: finish at once, MAC engine untouched
                        tag_ref_s = 128'd0;
                        error_s   = 1'b1;
                        done_s    = 1'b1;
                        state_s   = ST_DONE;
                    end
                end else if ((state_r == ST_READY) && final_i) begin
                    block_s = block_i;
                    i_len_s = i_len;
                    cmd_s   = CMD_FINAL;
                    state_s = ST_ISSUE;
                end else if ((state_r == ST_READY) && next) begin
                    block_s = block_i;
                    i_len_s = i_len;
                    cmd_s   = CMD_NEXT;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
                timer_s = TIMER_ZERO;
            end
            ST_WAIT: begin
                // timer_r == 0 marks the first WAIT cycle, where mac_ready may
                // still show the engine's pre-command status
                if ((timer_r != TIMER_ZERO) && mac_ready) begin
                    state_s = (cmd_r == CMD_FINAL) ? ST_CMP : ST_READY;
                end else if (timer_r >= TIMER_MAX) begin
                    error_s   = 1'b1;
                    done_s    = 1'b1;
                    tag_ok_s  = 1'b0;
                    tag_ref_s = 128'd0;
                    state_s   = ST_DONE;
                end else begin
                    // Never passes TIMER_MAX: the branch above exits first
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            ST_CMP: begin
                tag_ok_s  = match_s;
                done_s    = 1'b1;
                tag_ref_s = 128'd0;
                state_s   = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, data and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cmd_r       <= CMD_INIT;
            tag_len_r   <= 8'd0;
            tag_ref_r   <= 128'd0;
            block_r     <= 128'd0;
            i_len_r     <= 8'd0;
            timer_r     <= TIMER_ZERO;
            done_r      <= 1'b0;
            tag_ok_r    <= 1'b0;
            error_r     <= 1'b0;
            mac_init_r  <= 1'b0;
            mac_next_r  <= 1'b0;
            mac_final_r <= 1'b0;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            cmd_r       <= cmd_s;
            tag_len_r   <= tag_len_s;
            tag_ref_r   <= tag_ref_s;
            block_r     <= block_s;
            i_len_r     <= i_len_s;
            timer_r     <= timer_s;
            done_r      <= done_s;
            tag_ok_r    <= tag_ok_s;
            error_r     <= error_s;
            mac_init_r  <= (state_s == ST_ISSUE) && (cmd_s == CMD_INIT);
            mac_next_r  <= (state_s == ST_ISSUE) && (cmd_s == CMD_NEXT);
            mac_final_r <= (state_s == ST_ISSUE) && (cmd_s == CMD_FINAL);
            ready_r     <= (state_s == ST_IDLE) || (state_s == ST_READY) || (state_s == ST_DONE);
        end
    end

    assign mac_init    = mac_init_r;
    assign mac_next    = mac_next_r;
    assign mac_final   = mac_final_r;
    assign mac_block   = block_r;
    assign mac_i_len   = i_len_r;
    assign mac_tag_len = tag_len_r;
    assign ready       = ready_r;
    assign done        = done_r;
    assign tag_ok      = tag_ok_r;
    assign error       = error_r;

endmodule

// File: tb/tb_zuc256_mac_verify.sv
// Directed bench for zuc256_mac_verify with a behavioural mac_ext stub.
module tb_zuc256_mac_verify;

    localparam logic [127:0] STUB_TAG = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         init = 1'b0;
    logic         next = 1'b0;
    logic         final_i = 1'b0;
    logic [127:0] block_i = 128'd0;
    logic [7:0]   i_len = 8'd0;
    logic [7:0]   tag_len = 8'd0;
    logic [127:0] tag_i = 128'd0;
    logic         mac_init, mac_next, mac_final;
    logic [127:0] mac_block;
    logic [7:0]   mac_i_len, mac_tag_len;
    logic [127:0] mac_tag;
    logic         mac_ready;
    logic         ready, done, tag_ok, error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_init = 0, n_next = 0, n_final = 0;
    logic [63:0] plog = 64'd0;
    int stub_cnt = 0;
    logic stall = 1'b0;

    typedef struct {
        logic [7:0]   tl;
        logic [127:0] tag;
        int           n_nxt;
        logic         exp_ok;
        logic         exp_err;
    } vec_t;

    vec_t vecs [9];

    zuc256_mac_verify #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .next(next), .final_i(final_i),
        .block_i(block_i), .i_len(i_len), .tag_len(tag_len), .tag_i(tag_i),
        .mac_init(mac_init), .mac_next(mac_next), .mac_final(mac_final),
        .mac_block(mac_block), .mac_i_len(mac_i_len), .mac_tag_len(mac_tag_len),
        .mac_tag(mac_tag), .mac_ready(mac_ready),
        .ready(ready), .done(done), .tag_ok(tag_ok), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // mac_ext stub: busy one cycle after a pulse, ready again 5 cycles later
    always @(posedge clk) begin
        if (!reset_n) begin
            mac_ready <= 1'b1;
            stub_cnt  <= 0;
            mac_tag   <= 128'd0;
        end else if (mac_init || mac_next || mac_final) begin
            mac_ready <= 1'b0;
            stub_cnt  <= 5;
            if (mac_final) mac_tag <= STUB_TAG;
            else if (mac_init) mac_tag <= 128'd0;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stall) mac_ready <= 1'b1;
        end
    end

    // Pulse monitor: counts and order log (1=init, 2=next, 3=final)
    always @(posedge clk) begin
        if (mac_init) begin
            n_init <= n_init + 1;
            plog   <= {plog[59:0], 4'h1};
        end else if (mac_next) begin
            n_next <= n_next + 1;
            plog   <= {plog[59:0], 4'h2};
        end else if (mac_final) begin
            n_final <= n_final + 1;
            plog    <= {plog[59:0], 4'h3};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (ready !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        if (ready !== 1'b1) chk({name, "_ready_timeout"}, 128'(ready), 128'd1);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        if (done !== 1'b1) chk({name, "_done_timeout"}, 128'(done), 128'd1);
    endtask

    task automatic pulse_init(input logic [7:0] tl, input logic [127:0] t);
        tag_len = tl;
        tag_i   = t;
        init    = 1'b1;
        tick();
        init    = 1'b0;
        tag_len = 8'd0;
        tag_i   = ~t;
    endtask

    task automatic pulse_blk(input logic fin, input logic [127:0] blk, input logic [7:0] len);
        block_i = blk;
        i_len   = len;
        final_i = fin;
        next    = ~fin;
        tick();
        final_i = 1'b0;
        next    = 1'b0;
        block_i = 128'd0;
        i_len   = 8'd0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int s_init;
        logic [127:0] blk;
        logic [63:0] exp_log;
        logic [63:0] msk;
        string nm;
        nm = $sformatf("vec%0d", idx);
        wait_ready(nm);
        s_init = n_init;
        pulse_init(v.tl, v.tag);
        chk({nm, "_mac_tag_len"}, 128'(mac_tag_len), 128'(v.tl));
        if (v.exp_err) begin
            tick();
            chk({nm, "_done"}, 128'(done), 128'd1);
            chk({nm, "_error"}, 128'(error), 128'd1);
            chk({nm, "_tag_ok"}, 128'(tag_ok), 128'd0);
            chk({nm, "_no_mac_init"}, 128'(n_init - s_init), 128'd0);
        end else begin
            exp_log = 64'h1;
            for (int j = 0; j < v.n_nxt; j++) begin
                wait_ready(nm);
                blk = {4{32'(idx * 16 + j + 32'hA5A5_0000)}};
                pulse_blk(1'b0, blk, 8'd128);
                chk({nm, "_mac_block"}, mac_block, blk);
                chk({nm, "_mac_i_len"}, 128'(mac_i_len), 128'd128);
                exp_log = {exp_log[59:0], 4'h2};
            end
            wait_ready(nm);
            pulse_blk(1'b1, 128'hCAFE, 8'd40);
            chk({nm, "_final_i_len"}, 128'(mac_i_len), 128'd40);
            exp_log = {exp_log[59:0], 4'h3};
            wait_done(nm);
            chk({nm, "_done"}, 128'(done), 128'd1);
            chk({nm, "_tag_ok"}, 128'(tag_ok), 128'(v.exp_ok));
            chk({nm, "_error"}, 128'(error), 128'd0);
            msk = (64'd1 << (4 * (v.n_nxt + 2))) - 64'd1;
            chk({nm, "_pulse_order"}, 128'(plog & msk), 128'(exp_log));
        end
    endtask

    initial begin
        int s_next, s_final, c0, k;

        vecs[0] = '{8'd32,  128'h7654_3210, 2, 1'b1, 1'b0};
        vecs[1] = '{8'd32,  128'h7654_3211, 2, 1'b0, 1'b0};
        vecs[2] = '{8'd64,  128'hDEAD_BEEF_0BAD_F00D_FEDC_BA98_7654_3210, 1, 1'b1, 1'b0};
        vecs[3] = '{8'd48,  STUB_TAG, 0, 1'b0, 1'b1};
        vecs[4] = '{8'd128, STUB_TAG, 0, 1'b1, 1'b0};
        vecs[5] = '{8'd128, 128'h8123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 1'b0, 1'b0};
        vecs[6] = '{8'd32,  128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_7654_3210, 1, 1'b1, 1'b0};
        vecs[7] = '{8'd64,  128'h0000_0000_0000_0000_FEDC_BA99_7654_3210, 1, 1'b0, 1'b0};
        vecs[8] = '{8'd0,   STUB_TAG, 0, 1'b0, 1'b1};

        // Reset state
        reset_n = 1'b0;
        tick(); tick(); tick();
        chk("reset_ctrl", 128'({ready, done, tag_ok, error, mac_init, mac_next, mac_final}), 128'd0);
        chk("reset_data", 128'({mac_i_len, mac_tag_len}), 128'd0);
        chk("reset_block", mac_block, 128'd0);
        // next/final before any init are ignored
        reset_n = 1'b1;
        tick();
        chk("ready_after_reset", 128'(ready), 128'd1);
        s_next = n_next;
        pulse_blk(1'b0, 128'h1, 8'd8);
        pulse_blk(1'b1, 128'h1, 8'd8);
        tick();
        chk("idle_ignores_next_final", 128'(n_next - s_next + n_final), 128'd0);

        for (int v = 0; v < 9; v++) run_vec(vecs[v], v);

        // Sticky result held through ignored pulses, cleared by init
        run_vec(vecs[0], 100);
        tick(); tick(); tick();
        s_next = n_next;
        s_final = n_final;
        pulse_blk(1'b0, 128'h2, 8'd16);
        pulse_blk(1'b1, 128'h2, 8'd16);
        tick(); tick();
        chk("sticky_done", 128'(done), 128'd1);
        chk("sticky_tag_ok", 128'(tag_ok), 128'd1);
        chk("done_ignores_pulses", 128'((n_next - s_next) + (n_final - s_final)), 128'd0);
        pulse_init(8'd32, 128'h7654_3210);
        chk("init_clears_done", 128'({done, tag_ok, error}), 128'd0);

        // Simultaneous next+final: final wins; pulse while busy is dropped
        wait_ready("prio");
        s_next = n_next;
        block_i = 128'h3;
        i_len = 8'd24;
        next = 1'b1;
        final_i = 1'b1;
        tick();
        next = 1'b0;
        final_i = 1'b0;
        chk("prio_final", 128'({mac_final, mac_next}), 128'b10);
        tick();
        next = 1'b1;
        tick();
        next = 1'b0;
        wait_done("prio");
        chk("prio_tag_ok", 128'(tag_ok), 128'd1);
        chk("busy_pulse_dropped", 128'(n_next - s_next), 128'd0);

        // Timeout while mac_ext never becomes ready
        wait_ready("tmo");
        pulse_init(8'd32, 128'h7654_3210);
        wait_ready("tmo");
        stall = 1'b1;
        pulse_blk(1'b0, 128'h4, 8'd32);
        chk("tmo_next_pulse", 128'(mac_next), 128'd1);
        c0 = cyc;
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk("tmo_done", 128'(done), 128'd1);
        chk("tmo_latency", 128'(cyc - c0), 128'd18);
        chk("tmo_error", 128'(error), 128'd1);
        chk("tmo_tag_ok", 128'(tag_ok), 128'd0);
        stall = 1'b0;

        // Reset during WAIT, then a clean run
        pulse_init(8'd32, 128'h7654_3210);
        tick();
        reset_n = 1'b0;
        tick();
        chk("midreset_ctrl", 128'({ready, done, tag_ok, error, mac_init, mac_next, mac_final}), 128'd0);
        chk("midreset_data", 128'({mac_i_len, mac_tag_len}), 128'd0);
        reset_n = 1'b1;
        tick();
        chk("midreset_ready", 128'(ready), 128'd1);
        run_vec(vecs[0], 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
